// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared constants for the control-word pipeline and the decoders that feed it.
//   - Stage indices into the back-end pipeline (E, M, W).
//   - Default position of the multi-cycle flag inside the control word.
//   - Field positions of the control word, so the decoders and the
//     pipeline agree on where each control bit lives.
package pipe_ctrl_pkg;

    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    localparam int MC_BIT_DEF = 15;

    typedef enum logic [3:0] {
        CF_REG_WRITE  = 4'd0,
        CF_MEM_WRITE  = 4'd1,
        CF_MEM_TO_REG = 4'd2,
        CF_BRANCH     = 4'd3,
        CF_ALU_SRC    = 4'd4,
        CF_JUMP       = 4'd5,
        CF_MULTI_CYC  = 4'd15
    } ctrl_field_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   One pipeline register holding a control word and its valid bit.
//   Priority per edge: clear > hold > load > bubble.
//   An invalid word is always stored as all-zero control.
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   drop contents (valid=0, ctrl=0)
//   hold       in   keep current contents
//   load       in   capture ctrl_in/valid_in; if none of clear/hold/load, insert bubble
//   ctrl_in    in   upstream control word
//   valid_in   in   upstream valid
//   ctrl_out   out  stored control word
//   valid_out  out  stored valid
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] ctrl_in,
    input  logic          valid_in,
    output logic [CW-1:0] ctrl_out,
    output logic          valid_out
);

    logic [CW-1:0] ctrl_q, ctrl_d;
    logic          valid_q, valid_d;

    always_comb begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        if (clear) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (load) begin
            ctrl_d  = valid_in ? ctrl_in : '0;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
//   Control-word pipeline from D through STAGES back-end registers (E, M, W...).
//   Hazard stalls propagate upstream; flushes clear a single stage. Ops with
//   ctrl_d[MC_BIT] set stay in stage 0 for MC_CYCLES cycles.
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   ctrl_d      in   decoded control word (D stage)
//   valid_d     in   D holds a real instruction
//   stall_i     in   per-stage hold request
//   flush_i     in   per-stage clear request
//   ctrl_o      out  stage k word at [k*CW +: CW]
//   valid_o     out  stage k valid
//   stall_up_o  out  D/F must hold (effective stall of stage 0)
//   mc_busy_o   out  multi-cycle op holding stage 0
module pipe_ctrl_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int CW        = 16,
    parameter int STAGES    = 3,
    parameter int MC_BIT    = MC_BIT_DEF,
    parameter int MC_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic [STAGES-1:0]    stall_i,
    input  logic [STAGES-1:0]    flush_i,
    output logic [STAGES*CW-1:0] ctrl_o,
    output logic [STAGES-1:0]    valid_o,
    output logic                 stall_up_o,
    output logic                 mc_busy_o
);

    localparam int               CNT_W   = $clog2(MC_CYCLES + 1);
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mc_hold;
    logic [STAGES-1:0] st;
    logic              st_down;
    logic [CW-1:0]     ctrl_s [STAGES];
    logic [STAGES-1:0] valid_s;

    assign mc_hold = (cnt_q != '0);

    // Suffix-OR of stall requests: any stalled stage stalls everything upstream.
    // Written without reading st back so the chain stays a plain tree.
    always_comb begin
        logic acc;
        st = '0;
        for (int k = 0; k < STAGES; k++) begin
            acc = (k == 0) ? mc_hold : 1'b0;
            for (int j = k; j < STAGES; j++) begin
                acc = acc | stall_i[j];
            end
            st[k] = acc;
        end
    end

    // Effective stall of the stage just below E; freezes the MC countdown.
    generate
        if (STAGES > 1) begin : g_st_down
            assign st_down = st[1];
        end else begin : g_st_none
            assign st_down = 1'b0;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i[0]) begin
            cnt_d = '0;
        end else if (mc_hold) begin
            if (!st_down) cnt_d = cnt_q - 1'b1;
        end else if (!st[0] && valid_d && ctrl_d[MC_BIT]) begin
            cnt_d = MC_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [CW-1:0] up_ctrl;
            logic          up_valid;
            logic          up_load;

            if (k == 0) begin : g_head
                assign up_ctrl  = ctrl_d;
                assign up_valid = valid_d;
                assign up_load  = 1'b1;
            end else begin : g_tail
                assign up_ctrl  = ctrl_s[k-1];
                assign up_valid = valid_s[k-1];
                assign up_load  = !st[k-1];
            end

            pipe_stage_reg #(.CW(CW)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .clear     (flush_i[k]),
                .hold      (st[k]),
                .load      (up_load),
                .ctrl_in   (up_ctrl),
                .valid_in  (up_valid),
                .ctrl_out  (ctrl_s[k]),
                .valid_out (valid_s[k])
            );

            assign ctrl_o[k*CW +: CW] = ctrl_s[k];
        end
    endgenerate

    assign valid_o    = valid_s;
    assign stall_up_o = st[0];
    assign mc_busy_o  = mc_hold;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ctrl_d;
    logic        valid_d;
    logic [2:0]  stall_i;
    logic [2:0]  flush_i;
    logic [47:0] ctrl_o;
    logic [2:0]  valid_o;
    logic        stall_up_o;
    logic        mc_busy_o;

    int total = 0;
    int passed = 0;

    pipe_ctrl_chain #(.CW(16), .STAGES(3), .MC_BIT(15), .MC_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_d     (ctrl_d),
        .valid_d    (valid_d),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ctrl_o     (ctrl_o),
        .valid_o    (valid_o),
        .stall_up_o (stall_up_o),
        .mc_busy_o  (mc_busy_o)
    );

    always #5 clk = ~clk;

    wire [15:0] e_c = ctrl_o[15:0];
    wire [15:0] m_c = ctrl_o[31:16];
    wire [15:0] w_c = ctrl_o[47:32];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        valid_d = 1'b0;
        ctrl_d  = 16'h0000;
        stall_i = 3'b000;
        flush_i = 3'b000;
        repeat (4) tick();
    endtask

    initial begin
        reset   = 1'b0;
        ctrl_d  = 16'h0000;
        valid_d = 1'b0;
        stall_i = 3'b000;
        flush_i = 3'b000;
        #2;
        chk("rst_valid", 48'(valid_o), 48'h0);
        chk("rst_ctrl", ctrl_o, 48'h0);
        chk("rst_busy", 48'(mc_busy_o), 48'h0);
        chk("rst_stall_up", 48'(stall_up_o), 48'h0);
        @(negedge clk);
        reset = 1'b1;

        // 1. free flow, with garbage ctrl on an invalid D afterwards
        ctrl_d = 16'h0123; valid_d = 1'b1;
        tick();
        chk("ff_e_ctrl", 48'(e_c), 48'h0123);
        chk("ff_valid1", 48'(valid_o), 48'b001);
        ctrl_d = 16'hFFFF; valid_d = 1'b0;
        tick();
        chk("ff_m_ctrl", 48'(m_c), 48'h0123);
        chk("ff_e_zero", 48'(e_c), 48'h0);
        chk("ff_valid2", 48'(valid_o), 48'b010);
        tick();
        chk("ff_w_ctrl", 48'(w_c), 48'h0123);
        chk("ff_valid3", 48'(valid_o), 48'b100);
        tick();
        chk("ff_valid4", 48'(valid_o), 48'b000);
        drain();

        // 2. load-use stall on E
        ctrl_d = 16'h00A1; valid_d = 1'b1;
        tick();
        chk("lu_e_a", 48'(e_c), 48'h00A1);
        ctrl_d = 16'h00B2; stall_i = 3'b001;
        #1;
        chk("lu_stall_up", 48'(stall_up_o), 48'h1);
        tick();
        chk("lu_e_hold", 48'(e_c), 48'h00A1);
        chk("lu_m_bubble_v", 48'(valid_o[1]), 48'h0);
        chk("lu_m_bubble_c", 48'(m_c), 48'h0);
        stall_i = 3'b000;
        #1;
        chk("lu_stall_up_off", 48'(stall_up_o), 48'h0);
        tick();
        chk("lu_e_b", 48'(e_c), 48'h00B2);
        chk("lu_m_a", 48'(m_c), 48'h00A1);
        drain();

        // 3. multi-cycle op holds E for 4 cycles
        ctrl_d = 16'h8005; valid_d = 1'b1;
        tick();
        chk("mc_e1", 48'(e_c), 48'h8005);
        chk("mc_busy1", 48'(mc_busy_o), 48'h1);
        chk("mc_stall_up1", 48'(stall_up_o), 48'h1);
        ctrl_d = 16'h0042;
        tick();
        chk("mc_busy2", 48'(mc_busy_o), 48'h1);
        chk("mc_e2", 48'(e_c), 48'h8005);
        chk("mc_m_bub2", 48'({valid_o[1], m_c}), 48'h0);
        tick();
        chk("mc_busy3", 48'(mc_busy_o), 48'h1);
        chk("mc_m_bub3", 48'({valid_o[1], m_c}), 48'h0);
        tick();
        chk("mc_busy4", 48'(mc_busy_o), 48'h0);
        chk("mc_e4", 48'(e_c), 48'h8005);
        chk("mc_m_bub4", 48'({valid_o[1], m_c}), 48'h0);
        chk("mc_stall_up4", 48'(stall_up_o), 48'h0);
        valid_d = 1'b1;
        tick();
        chk("mc_m_op", 48'(m_c), 48'h8005);
        chk("mc_e_next", 48'(e_c), 48'h0042);
        chk("mc_busy5", 48'(mc_busy_o), 48'h0);
        drain();

        // 4. flush during multi-cycle hold
        ctrl_d = 16'h8005; valid_d = 1'b1;
        tick();
        ctrl_d = 16'h0077;
        tick();
        chk("fl_busy_c2", 48'(mc_busy_o), 48'h1);
        flush_i = 3'b001;
        tick();
        chk("fl_e_valid", 48'(valid_o[0]), 48'h0);
        chk("fl_e_ctrl", 48'(e_c), 48'h0);
        chk("fl_busy", 48'(mc_busy_o), 48'h0);
        flush_i = 3'b000;
        tick();
        chk("fl_e_next", 48'({valid_o[0], e_c}), {31'h0, 1'b1, 16'h0077});
        drain();

        // 5. stall + flush on M together
        ctrl_d = 16'h0C02; valid_d = 1'b1;
        tick();
        ctrl_d = 16'h0C01;
        tick();
        chk("sf_setup", 48'({m_c, e_c}), 48'h0C020C01);
        ctrl_d = 16'h0C03; stall_i = 3'b010; flush_i = 3'b010;
        #1;
        chk("sf_stall_up", 48'(stall_up_o), 48'h1);
        tick();
        chk("sf_m_clear", 48'({valid_o[1], m_c}), 48'h0);
        chk("sf_e_hold", 48'(e_c), 48'h0C01);
        chk("sf_w_bubble", 48'({valid_o[2], w_c}), 48'h0);
        stall_i = 3'b000; flush_i = 3'b000;
        tick();
        chk("sf_resume", 48'({m_c, e_c}), 48'h0C010C03);
        drain();

        // 6. async reset mid multi-cycle
        ctrl_d = 16'h8005; valid_d = 1'b1;
        tick();
        chk("ar_busy_pre", 48'(mc_busy_o), 48'h1);
        valid_d = 1'b0; ctrl_d = 16'h0000;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 48'(valid_o), 48'h0);
        chk("ar_ctrl", ctrl_o, 48'h0);
        chk("ar_busy", 48'(mc_busy_o), 48'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("ar_busy_after", 48'(mc_busy_o), 48'h0);
        ctrl_d = 16'h0055; valid_d = 1'b1;
        tick();
        chk("ar_reload", 48'({valid_o, e_c}), {29'h0, 3'b001, 16'h0055});
        chk("ar_no_busy", 48'(mc_busy_o), 48'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
